// File: rtl/count_sequence_checker_pkg.sv
// Shared constants and types for the count sequence checker.
//   state_e  : checker FSM states (hunt, sync, locked, fault)
//   ErrCntW  : width of the saturating mismatch counter
package count_sequence_checker_pkg;

  localparam int unsigned ErrCntW = 8;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2,
    StFault  = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter8.sv
// Saturating up-counter for mismatch events.
// Ports:
//   clock   : clock, rising edge
//   clear_n : asynchronous active-low reset
//   clr     : synchronous clear
//   inc     : increment request (saturates at all-ones)
//   count   : current count
// clr and inc on the same edge yield a count of 1.
module sat_counter8
  import count_sequence_checker_pkg::*;
(
  input  logic               clock,
  input  logic               clear_n,
  input  logic               clr,
  input  logic               inc,
  output logic [ErrCntW-1:0] count
);

  logic [ErrCntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? ErrCntW'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + ErrCntW'(1);
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Watches samples of a free-running counter and checks they increment by one.
// Hunts for a first sample, needs LOCK_LEN consecutive correct increments to
// lock, and flags a mismatch only while locked.
// Ports:
//   clock     : clock, rising edge
//   clear_n   : asynchronous active-low reset
//   q_in      : observed counter value
//   q_valid   : q_in is sampled on this edge
//   cnt_clear : observed counter is being cleared; expected sample is 0
//   err_clr   : synchronous clear of error and err_count
//   locked    : checker is tracking a valid sequence
//   error     : sticky mismatch flag
//   err_pulse : one-cycle pulse per mismatch while locked
//   err_count : saturating mismatch count
//   exp_q     : next expected value
module count_sequence_checker
  import count_sequence_checker_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_LEN = 2  // must be >= 1
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic [WIDTH-1:0]   q_in,
  input  logic               q_valid,
  input  logic               cnt_clear,
  input  logic               err_clr,
  output logic               locked,
  output logic               error,
  output logic               err_pulse,
  output logic [ErrCntW-1:0] err_count,
  output logic [WIDTH-1:0]   exp_q
);

  localparam int unsigned McW = $clog2(LOCK_LEN + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_val_q, exp_val_d;
  logic [McW-1:0]   mc_q, mc_d;
  logic             locked_q, error_q, pulse_q;

  logic [WIDTH-1:0] ref_val;
  logic [McW-1:0]   mc_inc;
  logic             hit;
  logic             fault_hit;

  // A cleared counter must read 0 regardless of what we expected.
  assign ref_val = cnt_clear ? '0 : exp_val_q;
  assign hit     = (q_in == ref_val);
  assign mc_inc  = mc_q + McW'(1);

  always_comb begin
    state_d   = state_q;
    exp_val_d = exp_val_q;
    mc_d      = mc_q;
    fault_hit = 1'b0;
    if (q_valid) begin
      unique case (state_q)
        StHunt, StFault: begin
          // Resynchronise on whatever we see; no error outside LOCKED.
          exp_val_d = q_in + WIDTH'(1);
          mc_d      = '0;
          state_d   = StSync;
        end
        StSync: begin
          if (hit) begin
            exp_val_d = ref_val + WIDTH'(1);
            mc_d      = mc_inc;
            if (mc_inc == McW'(LOCK_LEN)) begin
              state_d = StLocked;
            end
          end else begin
            exp_val_d = q_in + WIDTH'(1);
            mc_d      = '0;
          end
        end
        StLocked: begin
          if (hit) begin
            exp_val_d = ref_val + WIDTH'(1);
          end else begin
            fault_hit = 1'b1;
            state_d   = StFault;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= StHunt;
      exp_val_q <= '0;
      mc_q      <= '0;
      locked_q  <= 1'b0;
      error_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_val_q <= exp_val_d;
      mc_q      <= mc_d;
      locked_q  <= (state_d == StLocked);
      pulse_q   <= fault_hit;
      // A mismatch on the clearing edge wins: error stays set.
      if (err_clr) begin
        error_q <= fault_hit;
      end else if (fault_hit) begin
        error_q <= 1'b1;
      end
    end
  end

  sat_counter8 u_err_cnt (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (err_clr),
    .inc     (fault_hit),
    .count   (err_count)
  );

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_pulse = pulse_q;
  assign exp_q     = exp_val_q;

endmodule

// File: doc/count_sequence_checker.md
COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of the observed count.
REQ-002 Parameter LOCK_LEN, default 2: consecutive correct increments needed to lock.
REQ-003 clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 clear_n  input  1  reset, asynchronous, active-low.
REQ-005 q_in  input  WIDTH  observed counter output.
REQ-006 q_valid  input  1  q_in is sampled on this edge.
REQ-007 cnt_clear  input  1  the observed counter's clear; while high, the expected sample is 0.
REQ-008 err_clr  input  1  synchronous clear of the sticky error and the error count.
REQ-009 locked  output  1  checker is tracking a valid sequence.
REQ-010 error  output  1  sticky mismatch flag.
REQ-011 err_pulse  output  1  one-cycle pulse per detected mismatch.
REQ-012 err_count  output  8  saturating mismatch count.
REQ-013 exp_q  output  WIDTH  next expected value.

Function
REQ-014 The FSM SHALL have states HUNT, SYNC, LOCKED, FAULT; no other state.
REQ-015 Cycles with q_valid=0 SHALL leave all state, exp_q and the counters unchanged, and err_pulse=0.
REQ-016 HUNT, q_valid=1: exp_q <= q_in+1 mod 2^WIDTH; match count <= 0; go to SYNC.
REQ-017 SYNC, q_valid=1, q_in==exp_q: exp_q increments and the match count increments; when it reaches LOCK_LEN, go to LOCKED.
REQ-018 SYNC, q_valid=1, mismatch: exp_q <= q_in+1; match count <= 0; stay in SYNC; no error is reported.
REQ-019 LOCKED, q_valid=1, match: exp_q <= exp_q+1, wrapping 2^WIDTH-1 to 0 with no error.
REQ-020 LOCKED, q_valid=1, mismatch: err_pulse=1 for the next cycle only; error <= 1; err_count += 1, saturating at 255; go to FAULT.
REQ-021 FAULT, q_valid=1: exp_q <= q_in+1; match count <= 0; go to SYNC; no further error is reported.
REQ-022 With cnt_clear=1 and q_valid=1, the compared value SHALL be 0 instead of exp_q, and the next exp_q SHALL be 1; all other rules are unchanged.
REQ-023 locked SHALL be 1 exactly while the state is LOCKED.
REQ-024 All outputs SHALL be registered; the response to a sample appears the cycle after the sampling edge.
REQ-025 err_clr=1 SHALL zero error and err_count; if a mismatch occurs on the same edge, the result SHALL be error=1 and err_count=1.
REQ-026 err_count at 255 SHALL hold 255; error and err_pulse still assert on each mismatch.

Reset
REQ-027 Asynchronously, while clear_n=0, the block SHALL hold: state HUNT, locked=0, error=0, err_pulse=0, err_count=0, exp_q=0, match count=0.
REQ-028 Reset asserted mid-operation (any state) SHALL return immediately to the REQ-027 values; the first sample after release follows the HUNT rules.

Structure
REQ-029 The FSM state encoding and the 8-bit error-count width SHALL be constants in the shared package.
REQ-030 The saturating error counter SHALL be one sub-module, sat_counter8, with clear, increment and clear-with-increment behaviour.
REQ-031 The rest of the block SHALL be a single FSM with its datapath; it SHALL contain no latches.

Verification
REQ-032 Reset, then q_in=3,4,5,6 with q_valid=1 every cycle -> locked=1 one cycle after the third sample, exp_q=7, error=0.
REQ-033 While locked, q_in=14,15,0,1 -> no err_pulse; exp_q=2.
REQ-034 While locked, q_in=5 when exp_q=5, then q_in=9 -> err_pulse high for exactly one cycle, error=1, err_count=1, locked=0; then q_in=10,11,12 -> locked=1 again, error still 1.
REQ-035 While locked, cnt_clear=1 with q_in=0, then cnt_clear=0 with q_in=1,2 -> no error, locked stays 1.
REQ-036 Force 256 lock-then-mismatch cycles -> err_count=255; then err_clr=1 on the same edge as a mismatch -> err_count=1, error=1.
REQ-037 clear_n pulsed low for 3 ns between clock edges while LOCKED -> outputs reach reset values with no clock edge; the next sample restarts HUNT.
